// File: rtl/inst_loader_ctrl_pkg.sv
// Shared boot-loader definitions: state encoding, default boot constants, address helper.
package inst_loader_ctrl_pkg;

  localparam int unsigned LDR_BYTE_W  = 8;
  localparam int unsigned LDR_DATA_W  = 32;
  localparam int unsigned LDR_ADDR_W  = 32;
  localparam int unsigned LDR_COUNT_W = 16;
  localparam int unsigned LDR_TMO_W   = 16;

  localparam logic [LDR_ADDR_W-1:0] LDR_BASE_ADDR   = 32'h0000_0000;
  localparam int unsigned           LDR_ADDR_STEP   = 4;
  localparam int unsigned           LDR_MAX_WORDS   = 1024;
  localparam int unsigned           LDR_TIMEOUT_CYC = 65535;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_RECV  = 3'd1,
    LDR_WRITE = 3'd2,
    LDR_RUN   = 3'd3,
    LDR_ERR   = 3'd4
  } ldr_state_e;

  // Word address with 32-bit wraparound.
  function automatic logic [LDR_ADDR_W-1:0] ldr_addr(input logic [LDR_ADDR_W-1:0] base,
                                                     input logic [LDR_COUNT_W-1:0] idx,
                                                     input int unsigned step);
    return base + 32'(idx) * 32'(step);
  endfunction

endpackage

// File: rtl/inst_loader_ctrl_if.sv
// Byte-stream input and instruction-load output bundle of the boot loader.
interface inst_loader_ctrl_if;
  import inst_loader_ctrl_pkg::*;

  logic                  byte_valid;
  logic [LDR_BYTE_W-1:0] byte_data;
  logic                  byte_ready;
  logic                  load_en;
  logic [LDR_ADDR_W-1:0] Inst_addr_load;
  logic [LDR_DATA_W-1:0] Inst_load;

  // Controller side.
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, load_en, Inst_addr_load, Inst_load
  );

  // Byte producer / instruction memory side.
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, load_en, Inst_addr_load, Inst_load
  );
endinterface

// File: rtl/inst_loader_ctrl_assembler.sv
// Little-endian byte-to-word assembler; word_c already includes the byte being accepted.
module ldr_word_assembler
  import inst_loader_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [LDR_BYTE_W-1:0] byte_data,
  output logic [LDR_DATA_W-1:0] word_c,
  output logic                  word_ready_c
);

  logic [1:0]            byte_idx;
  logic [LDR_DATA_W-1:0] shift_q;

  // Byte index and partially assembled word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      shift_q  <= word_c;
    end
  end

  // Merge the incoming byte into its lane.
  always_comb begin
    word_c = shift_q;
    case (byte_idx)
      2'd0:    word_c[7:0]   = byte_data;
      2'd1:    word_c[15:8]  = byte_data;
      2'd2:    word_c[23:16] = byte_data;
      default: word_c[31:24] = byte_data;
    endcase
  end

  assign word_ready_c = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/inst_loader_ctrl.sv
// Boot sequencer: fills instruction memory from a byte stream, then releases the core.
module inst_loader_ctrl
  import inst_loader_ctrl_pkg::*;
#(
  parameter logic [LDR_ADDR_W-1:0] BASE_ADDR   = LDR_BASE_ADDR,
  parameter int unsigned           ADDR_STEP   = LDR_ADDR_STEP,
  parameter int unsigned           MAX_WORDS   = LDR_MAX_WORDS,
  parameter int unsigned           TIMEOUT_CYC = LDR_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LDR_COUNT_W-1:0] word_count,
  inst_loader_ctrl_if.master     bus,
  output logic                   cpu_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  ldr_state_e             state;
  logic [LDR_COUNT_W-1:0] word_cnt;
  logic [LDR_COUNT_W-1:0] word_idx;
  logic [LDR_TMO_W-1:0]   tmo_cnt;

  logic                  accept_c;
  logic                  start_ok_c;
  logic                  asm_clear_c;
  logic                  word_ready_c;
  logic [LDR_DATA_W-1:0] word_c;

  assign accept_c    = bus.byte_valid && bus.byte_ready;
  assign start_ok_c  = (word_count != '0) && (32'(word_count) <= MAX_WORDS);
  assign asm_clear_c = start && ((state == LDR_IDLE) || (state == LDR_RUN) || (state == LDR_ERR));

  ldr_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (asm_clear_c),
    .accept       (accept_c),
    .byte_data    (bus.byte_data),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  // Load FSM with word/timeout counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= LDR_IDLE;
      word_cnt           <= '0;
      word_idx           <= '0;
      tmo_cnt            <= '0;
      bus.byte_ready     <= 1'b0;
      bus.load_en        <= 1'b0;
      bus.Inst_addr_load <= '0;
      bus.Inst_load      <= '0;
      cpu_rst_n          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      bus.load_en <= 1'b0;
      case (state)
        LDR_IDLE, LDR_RUN, LDR_ERR: begin
          if (start) begin
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            if (start_ok_c) begin
              state          <= LDR_RECV;
              word_cnt       <= word_count;
              word_idx       <= '0;
              tmo_cnt        <= '0;
              bus.byte_ready <= 1'b1;
              busy           <= 1'b1;
              err            <= 1'b0;
            end else begin
              state          <= LDR_ERR;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              err            <= 1'b1;
            end
          end
        end
        LDR_RECV: begin
          if (accept_c) begin
            tmo_cnt <= '0;
            if (word_ready_c) begin
              state              <= LDR_WRITE;
              bus.byte_ready     <= 1'b0;
              bus.load_en        <= 1'b1;
              bus.Inst_load      <= word_c;
              bus.Inst_addr_load <= ldr_addr(BASE_ADDR, word_idx, ADDR_STEP);
            end
          end else if (tmo_cnt == LDR_TMO_W'(TIMEOUT_CYC - 1)) begin
            state          <= LDR_ERR;
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        LDR_WRITE: begin
          word_idx <= word_idx + 16'd1;
          tmo_cnt  <= '0;
          if ((word_idx + 16'd1) == word_cnt) begin
            state     <= LDR_RUN;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b1;
            done      <= 1'b1;
          end else begin
            state          <= LDR_RECV;
            bus.byte_ready <= 1'b1;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader_ctrl.sv
// Directed self-checking bench for the instruction boot loader.
module tb_inst_loader_ctrl;
  import inst_loader_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] word_count;
  logic        cpu_rst_n, busy, done, err;

  inst_loader_ctrl_if bus ();

  inst_loader_ctrl #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          acc_cnt = 0;

  // Record every memory write and every accepted byte.
  always @(posedge clk) begin
    if (bus.load_en) begin
      wr_addr_q.push_back(bus.Inst_addr_load);
      wr_data_q.push_back(bus.Inst_load);
    end
    if (bus.byte_valid && bus.byte_ready) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 40 && !got; i++) begin
      got = bus.byte_ready;
      @(posedge clk);
      @(negedge clk);
    end
    chk("byte_accept_wait", 32'(got), 32'd1);
  endtask

  task automatic do_start(input logic [15:0] wc);
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_load_en"},    32'(bus.load_en),    32'd0);
    chk({tag, "_addr"},       bus.Inst_addr_load,  32'd0);
    chk({tag, "_data"},       bus.Inst_load,       32'd0);
    chk({tag, "_cpu_rst_n"},  32'(cpu_rst_n),      32'd0);
    chk({tag, "_busy"},       32'(busy),           32'd0);
    chk({tag, "_done"},       32'(done),           32'd0);
    chk({tag, "_err"},        32'(err),            32'd0);
  endtask

  logic [7:0] img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  int         gaps [8] = '{3, 0, 5, 1, 0, 7, 2, 4};
  int         n0, a0;

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    word_count     = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load, back-to-back bytes.
    n0 = wr_addr_q.size();
    a0 = acc_cnt;
    do_start(16'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_byte_ready", 32'(bus.byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    bus.byte_valid = 1'b0;
    chk("basic_w2_load_en", 32'(bus.load_en), 32'd1);
    chk("basic_w2_ready_low", 32'(bus.byte_ready), 32'd0);
    chk("basic_w2_cpu_rst", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    chk("basic_run_cpu_rst", 32'(cpu_rst_n), 32'd1);
    chk("basic_run_done", 32'(done), 32'd1);
    chk("basic_run_busy", 32'(busy), 32'd0);
    chk("basic_run_load_en", 32'(bus.load_en), 32'd0);
    chk("basic_nwrites", 32'(wr_addr_q.size() - n0), 32'd2);
    chk("basic_addr0", wr_addr_q[n0], 32'h0000_0000);
    chk("basic_data0", wr_data_q[n0], 32'h0000_0013);
    chk("basic_addr1", wr_addr_q[n0+1], 32'h0000_0004);
    chk("basic_data1", wr_data_q[n0+1], 32'h0010_0093);
    chk("basic_accepts", 32'(acc_cnt - a0), 32'd8);

    // Restart from RUN, with an ignored start in the middle of receiving.
    n0 = wr_addr_q.size();
    do_start(16'd1);
    chk("rerun_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("rerun_done", 32'(done), 32'd0);
    chk("rerun_busy", 32'(busy), 32'd1);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    bus.byte_valid = 1'b0;
    do_start(16'd0);
    chk("ign_start_err", 32'(err), 32'd0);
    chk("ign_start_busy", 32'(busy), 32'd1);
    chk("ign_start_ready", 32'(bus.byte_ready), 32'd1);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    bus.byte_valid = 1'b0;
    chk("rerun_load_en", 32'(bus.load_en), 32'd1);
    chk("rerun_addr", bus.Inst_addr_load, 32'h0000_0000);
    chk("rerun_data", bus.Inst_load, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rerun_done_after", 32'(done), 32'd1);
    chk("rerun_nwrites", 32'(wr_addr_q.size() - n0), 32'd1);

    // Illegal counts.
    n0 = wr_addr_q.size();
    do_start(16'd0);
    chk("cnt0_err", 32'(err), 32'd1);
    chk("cnt0_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("cnt0_done", 32'(done), 32'd0);
    chk("cnt0_busy", 32'(busy), 32'd0);
    do_start(16'd1025);
    chk("cnt1025_err", 32'(err), 32'd1);
    chk("cnt1025_ready", 32'(bus.byte_ready), 32'd0);
    chk("cnt1025_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("badcnt_nwrites", 32'(wr_addr_q.size() - n0), 32'd0);

    // Largest legal count, then reset after five bytes.
    do_start(16'd1024);
    chk("cnt1024_err", 32'(err), 32'd0);
    chk("cnt1024_busy", 32'(busy), 32'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    n0 = wr_addr_q.size();
    do_start(16'd1);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    bus.byte_valid = 1'b0;
    chk("postrst_addr", bus.Inst_addr_load, 32'h0000_0000);
    chk("postrst_data", bus.Inst_load, 32'h1234_5678);
    @(negedge clk);
    chk("postrst_done", 32'(done), 32'd1);
    chk("postrst_nwrites", 32'(wr_addr_q.size() - n0), 32'd1);

    // Stalled stream; byte 4 is held valid across the write cycle.
    n0 = wr_addr_q.size();
    a0 = acc_cnt;
    do_start(16'd2);
    for (int i = 0; i < 8; i++) send_byte(img[i], gaps[i]);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_nwrites", 32'(wr_addr_q.size() - n0), 32'd2);
    chk("stall_addr0", wr_addr_q[n0], 32'h0000_0000);
    chk("stall_data0", wr_data_q[n0], 32'h0000_0013);
    chk("stall_addr1", wr_addr_q[n0+1], 32'h0000_0004);
    chk("stall_data1", wr_data_q[n0+1], 32'h0010_0093);
    chk("stall_accepts", 32'(acc_cnt - a0), 32'd8);

    // Timeout after two bytes with a 16-cycle limit.
    n0 = wr_addr_q.size();
    do_start(16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    bus.byte_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_15_err", 32'(err), 32'd0);
    chk("tmo_15_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tmo_16_err", 32'(err), 32'd1);
    chk("tmo_16_ready", 32'(bus.byte_ready), 32'd0);
    chk("tmo_16_busy", 32'(busy), 32'd0);
    chk("tmo_16_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("tmo_nwrites", 32'(wr_addr_q.size() - n0), 32'd0);

    // Leaving ERR with a legal start.
    do_start(16'd1);
    chk("err_exit_err", 32'(err), 32'd0);
    chk("err_exit_busy", 32'(busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
